masked_and_driver: RTL

MASKED_AND_DRIVER -- requirements
Module: masked_and_driver

---
 rtl/masked_and_driver.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/masked_and_driver.sv
// masked_and_driver: runs one first-order masked AND through an external two-share
// gadget, using fresh LFSR masks per operation and a bounded wait for the gadget.
module masked_and_driver #(
    parameter int          D       = 2,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 a,
    input  logic                 b,
    output logic [0:D-1]         ina,
    output logic [0:D-1]         inb,
    output logic [0:D*(D-1)/2-1] rin,
    output logic                 AndEnable,
    input  logic                 AndDone,
    input  logic [0:D-1]         out_sh,
    output logic                 busy,
    output logic                 done,
    output logic                 result,
    output logic                 err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        MASK,
        RUN,
        UNMASK,
        DONE,
        ERR
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;
    logic          a_q;
    logic          b_q;
    logic [0:D-1]  cap;

    // Taps 16,14,13,11 expressed on a register that shifts toward bit 0.
    assign lfsr_fb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign cnt_inc     = cnt + CW'(1);
    assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        busy    = (state != IDLE);
        done    = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = MASK;
                end
            end
            MASK: begin
                state_d = RUN;
            end
            RUN: begin
                if (AndDone) begin
                    state_d = UNMASK;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            UNMASK: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    // Plain operands live only in a_q/b_q; the gadget only ever sees them XORed with a mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ina       <= '0;
            inb       <= '0;
            rin       <= '0;
            AndEnable <= 1'b0;
            cnt       <= '0;
            cap       <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            result    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                MASK: begin
                    ina       <= {a_q ^ lfsr[0], lfsr[0]};
                    inb       <= {b_q ^ lfsr[1], lfsr[1]};
                    rin       <= lfsr[2];
                    cnt       <= '0;
                    AndEnable <= 1'b1;
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (AndDone) begin
                        cap       <= out_sh;
                        AndEnable <= 1'b0;
                    end else if (timeout_hit) begin
                        AndEnable <= 1'b0;
                        err       <= 1'b1;
                    end
                end
                UNMASK: begin
                    result <= cap[0] ^ cap[1];
                    ina    <= '0;
                    inb    <= '0;
                    rin    <= '0;
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
